// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse front end: synchronises the raw PS/2 lines, deframes bytes,
// assembles 3-byte packets and integrates the X delta into a clamped position.
module ps2_mouse_tracker #(
    parameter int unsigned X_INIT         = 100,
    parameter int unsigned X_MAX          = 639,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic        clock,
    input  logic        reset_,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] mouse_x,
    output logic        mouse_pressed_,
    output logic        packet_valid,
    output logic        frame_error
);

    localparam int unsigned XW = 16;
    localparam int unsigned SW = 18;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_clk_meta;
    logic            r_clk_sync;
    logic            r_clk_prev;
    logic            r_data_meta;
    logic            r_data_sync;

    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_par_ok;
    logic [1:0]      r_byte_idx;
    logic            r_btn;
    logic            r_sign;
    logic            r_ovf;
    logic [7:0]      r_mag;
    logic [TW-1:0]   r_timeout;
    logic [XW-1:0]   r_mouse_x;
    logic            r_pressed_n;
    logic            r_pkt_valid;
    logic            r_frame_err;

    logic [2:0]      w_bit_cnt_nxt;
    logic [7:0]      w_shift_nxt;
    logic            w_par_ok_nxt;
    logic [1:0]      w_byte_idx_nxt;
    logic            w_btn_nxt;
    logic            w_sign_nxt;
    logic            w_ovf_nxt;
    logic [7:0]      w_mag_nxt;
    logic [TW-1:0]   w_timeout_nxt;
    logic [XW-1:0]   w_mouse_x_nxt;
    logic            w_pressed_n_nxt;
    logic            w_pkt_valid_nxt;
    logic            w_frame_err_nxt;

    logic            w_fall;
    logic            w_active;
    logic signed [SW-1:0] w_delta;
    logic signed [SW-1:0] w_sum;
    logic [XW-1:0]   w_x_clamped;

    assign w_fall   = r_clk_prev & ~r_clk_sync;
    assign w_active = (r_state != S_IDLE) || (r_byte_idx != 2'd0);

    // Integrate the stored delta; an overflowed packet contributes nothing.
    always_comb begin
        w_delta     = r_ovf ? SW'(0) : {{9{r_sign}}, r_sign, r_mag};
        w_sum       = $signed({2'b00, r_mouse_x}) + w_delta;
        w_x_clamped = w_sum[XW-1:0];
        if (w_sum < 0) begin
            w_x_clamped = '0;
        end else if (w_sum > $signed(SW'(X_MAX))) begin
            w_x_clamped = XW'(X_MAX);
        end
    end

    // Frame FSM, packet assembly and timeout next-state logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_par_ok_nxt    = r_par_ok;
        w_byte_idx_nxt  = r_byte_idx;
        w_btn_nxt       = r_btn;
        w_sign_nxt      = r_sign;
        w_ovf_nxt       = r_ovf;
        w_mag_nxt       = r_mag;
        w_timeout_nxt   = r_timeout;
        w_mouse_x_nxt   = r_mouse_x;
        w_pressed_n_nxt = r_pressed_n;
        w_pkt_valid_nxt = 1'b0;
        w_frame_err_nxt = 1'b0;

        if (w_fall) begin
            w_timeout_nxt = '0;
            case (r_state)
                S_IDLE: begin
                    if (!r_data_sync) begin
                        w_state_nxt   = S_DATA;
                        w_bit_cnt_nxt = 3'd0;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end
                S_DATA: begin
                    w_shift_nxt = {r_data_sync, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
                S_PARITY: begin
                    w_par_ok_nxt = ^{r_shift, r_data_sync};
                    w_state_nxt  = S_STOP;
                end
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (r_data_sync && r_par_ok) begin
                        case (r_byte_idx)
                            2'd0: begin
                                // Bit 3 is always set in a header byte; anything else is a resync.
                                if (r_shift[3]) begin
                                    w_btn_nxt      = r_shift[0];
                                    w_sign_nxt     = r_shift[4];
                                    w_ovf_nxt      = r_shift[6];
                                    w_byte_idx_nxt = 2'd1;
                                end
                            end
                            2'd1: begin
                                w_mag_nxt      = r_shift;
                                w_byte_idx_nxt = 2'd2;
                            end
                            2'd2: begin
                                w_mouse_x_nxt   = w_x_clamped;
                                w_pressed_n_nxt = ~r_btn;
                                w_pkt_valid_nxt = 1'b1;
                                w_byte_idx_nxt  = 2'd0;
                            end
                            default: begin
                                w_byte_idx_nxt = 2'd0;
                            end
                        endcase
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_byte_idx_nxt  = 2'd0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else if (w_active) begin
            if (r_timeout == TW'(TIMEOUT_CYCLES)) begin
                w_state_nxt     = S_IDLE;
                w_byte_idx_nxt  = 2'd0;
                w_timeout_nxt   = '0;
                w_frame_err_nxt = 1'b1;
            end else begin
                w_timeout_nxt = r_timeout + TW'(1);
            end
        end else begin
            w_timeout_nxt = '0;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Synchronisers, datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_par_ok    <= 1'b0;
            r_byte_idx  <= 2'd0;
            r_btn       <= 1'b0;
            r_sign      <= 1'b0;
            r_ovf       <= 1'b0;
            r_mag       <= 8'd0;
            r_timeout   <= '0;
            r_mouse_x   <= XW'(X_INIT);
            r_pressed_n <= 1'b1;
            r_pkt_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_clk_meta  <= ps2_clk;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data;
            r_data_sync <= r_data_meta;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_par_ok    <= w_par_ok_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_btn       <= w_btn_nxt;
            r_sign      <= w_sign_nxt;
            r_ovf       <= w_ovf_nxt;
            r_mag       <= w_mag_nxt;
            r_timeout   <= w_timeout_nxt;
            r_mouse_x   <= w_mouse_x_nxt;
            r_pressed_n <= w_pressed_n_nxt;
            r_pkt_valid <= w_pkt_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign mouse_x        = r_mouse_x;
    assign mouse_pressed_ = r_pressed_n;
    assign packet_valid   = r_pkt_valid;
    assign frame_error    = r_frame_err;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: drives PS/2 frames and checks the
// integrated position, button state and pulse counts against hand values.
module tb_ps2_mouse_tracker;

    logic        clock;
    logic        reset_;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] mouse_x;
    logic        mouse_pressed_;
    logic        packet_valid;
    logic        frame_error;

    int checks;
    int errors;
    int pv_cnt;
    int fe_cnt;
    int both_cnt;

    ps2_mouse_tracker #(
        .X_INIT         (100),
        .X_MAX          (639),
        .TIMEOUT_CYCLES (2000)
    ) dut (
        .clock          (clock),
        .reset_         (reset_),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .mouse_x        (mouse_x),
        .mouse_pressed_ (mouse_pressed_),
        .packet_valid   (packet_valid),
        .frame_error    (frame_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse monitors, sampled on the inactive edge.
    always @(negedge clock) begin
        if (reset_) begin
            if (packet_valid) pv_cnt++;
            if (frame_error) fe_cnt++;
            if (packet_valid && frame_error) both_cnt++;
        end
    end

    task automatic send_bit(input logic v);
        ps2_data = v;
        #20 ps2_clk = 1'b0;
        #40 ps2_clk = 1'b1;
        #20;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        #200;
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0, 1'b0);
        send_byte(b1, 1'b0, 1'b0);
        send_byte(b2, 1'b0, 1'b0);
        repeat (10) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset_ = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_ = 1'b1;
    endtask

    task automatic check_pos(input string name, input logic [15:0] exp_x, input logic exp_p);
        checks++;
        if (mouse_x !== exp_x) begin
            errors++;
            $display("FAIL %s mouse_x got %0d expected %0d", name, mouse_x, exp_x);
        end
        checks++;
        if (mouse_pressed_ !== exp_p) begin
            errors++;
            $display("FAIL %s mouse_pressed_ got %0b expected %0b", name, mouse_pressed_, exp_p);
        end
    endtask

    task automatic check_cnt(input string name, input int got, input int exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s count got %0d expected %0d", name, got, exp_v);
        end
    endtask

    task automatic test_reset;
        int pv0, fe0;
        @(negedge clock);
        reset_ = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (mouse_x !== 16'd100 || mouse_pressed_ !== 1'b1 || packet_valid !== 1'b0 || frame_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got x=%0d p=%0b pv=%0b fe=%0b expected 100 1 0 0",
                     mouse_x, mouse_pressed_, packet_valid, frame_error);
        end
        reset_ = 1'b1;
        pv0 = pv_cnt; fe0 = fe_cnt;
        repeat (5000) @(posedge clock);
        @(negedge clock);
        check_pos("idle_hold", 16'd100, 1'b1);
        check_cnt("idle_pv", pv_cnt - pv0, 0);
        check_cnt("idle_fe", fe_cnt - fe0, 0);
    endtask

    task automatic test_basic;
        int pv0;
        pv0 = pv_cnt;
        send_packet(8'h09, 8'h05, 8'h00);
        check_pos("basic_press", 16'd105, 1'b0);
        check_cnt("basic_pv", pv_cnt - pv0, 1);
        send_packet(8'h08, 8'h00, 8'h00);
        check_pos("basic_release", 16'd105, 1'b1);
        check_cnt("basic_pv2", pv_cnt - pv0, 2);
    endtask

    task automatic test_clamp;
        int pv0;
        send_packet(8'h18, 8'h9A, 8'h00);
        check_pos("neg_102", 16'd3, 1'b1);
        send_packet(8'h18, 8'hF6, 8'h00);
        check_pos("clamp_low", 16'd0, 1'b1);
        send_packet(8'h08, 8'hFF, 8'h00);
        send_packet(8'h08, 8'hFF, 8'h00);
        send_packet(8'h08, 8'h7D, 8'h00);
        check_pos("pos_635", 16'd635, 1'b1);
        send_packet(8'h08, 8'h0A, 8'h00);
        check_pos("clamp_high", 16'd639, 1'b1);
        pv0 = pv_cnt;
        send_packet(8'h48, 8'h7F, 8'h00);
        check_pos("overflow_hold", 16'd639, 1'b1);
        check_cnt("overflow_pv", pv_cnt - pv0, 1);
    endtask

    task automatic test_resync;
        int pv0, fe0;
        do_reset();
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h05, 1'b0, 1'b0);
        send_packet(8'h08, 8'h02, 8'h00);
        check_pos("resync", 16'd102, 1'b1);
        check_cnt("resync_pv", pv_cnt - pv0, 1);
        check_cnt("resync_fe", fe_cnt - fe0, 0);
    endtask

    task automatic test_frame_errors;
        int pv0, fe0;
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h04, 1'b1, 1'b0);
        check_cnt("parity_fe", fe_cnt - fe0, 1);
        check_pos("parity_hold", 16'd102, 1'b1);
        send_packet(8'h08, 8'h04, 8'h00);
        check_pos("parity_recover", 16'd106, 1'b1);
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b1);
        check_cnt("stop_fe", fe_cnt - fe0, 2);
        check_pos("stop_hold", 16'd106, 1'b1);
        send_packet(8'h08, 8'h01, 8'h00);
        check_pos("stop_recover", 16'd107, 1'b1);
        check_cnt("frame_err_pv", pv_cnt - pv0, 2);
    endtask

    task automatic test_timeout;
        int pv0, fe0;
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        repeat (2500) @(posedge clock);
        @(negedge clock);
        check_cnt("timeout_fe", fe_cnt - fe0, 1);
        check_pos("timeout_hold", 16'd107, 1'b1);
        send_packet(8'h09, 8'h01, 8'h00);
        check_pos("timeout_recover", 16'd108, 1'b0);
        check_cnt("timeout_pv", pv_cnt - pv0, 1);
        check_cnt("timeout_fe_once", fe_cnt - fe0, 1);
    endtask

    task automatic test_reset_mid;
        int pv0, fe0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clock);
        reset_ = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_pos("midreset", 16'd100, 1'b1);
        checks++;
        if (packet_valid !== 1'b0 || frame_error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pulses got pv=%0b fe=%0b expected 0 0", packet_valid, frame_error);
        end
        ps2_data = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_ = 1'b1;
        pv0 = pv_cnt; fe0 = fe_cnt;
        repeat (50) @(posedge clock);
        send_packet(8'h08, 8'h02, 8'h00);
        check_pos("after_midreset", 16'd102, 1'b1);
        check_cnt("after_midreset_pv", pv_cnt - pv0, 1);
        check_cnt("after_midreset_fe", fe_cnt - fe0, 0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        pv_cnt   = 0;
        fe_cnt   = 0;
        both_cnt = 0;
        reset_   = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        test_reset();
        test_basic();
        test_clamp();
        test_resync();
        test_frame_errors();
        test_timeout();
        test_reset_mid();
        check_cnt("pv_fe_overlap", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
